n64a_vdc_tx: RTL and testbench

//  Transmitter for the N64 multiplexed digital video bus: nDSYNC plus D[6:0], one

---
 rtl/n64a_vdc_tx_pkg.sv | 27 ++
 rtl/n64a_vdc_tx_if.sv | 21 ++
 rtl/n64a_vdc_hold.sv | 31 +++
 rtl/n64a_vdc_tx.sv | 101 ++++++++++
 tb/tb_n64a_vdc_tx.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/n64a_vdc_tx_pkg.sv
// rtl/n64a_vdc_tx_pkg.sv - widths, phase encoding and pixel word type for the N64 video bus transmitter
package n64a_vdc_tx_pkg;

  localparam int color_width = 7;
  localparam int sync_width  = 4;

  // Names give the phase shown on nDSYNC/D after the clock edge.
  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_PS   = 3'd1,
    PH_PR   = 3'd2,
    PH_PG   = 3'd3,
    PH_PB   = 3'd4
  } phase_t;

  typedef struct packed {
    logic [sync_width-1:0]  sync;
    logic [color_width-1:0] r;
    logic [color_width-1:0] g;
    logic [color_width-1:0] b;
  } pix_t;

  function automatic logic [color_width-1:0] sync_to_d(input logic [sync_width-1:0] s);
    return {{(color_width-sync_width){1'b0}}, s};
  endfunction

endpackage

// File: rtl/n64a_vdc_tx_if.sv
// rtl/n64a_vdc_tx_if.sv - parallel pixel valid/ready port of the video bus transmitter
interface n64a_vdc_tx_if;
  import n64a_vdc_tx_pkg::*;

  logic                   pix_valid_i;
  logic                   pix_ready_o;
  logic [sync_width-1:0]  pix_sync_i;
  logic [color_width-1:0] pix_r_i;
  logic [color_width-1:0] pix_g_i;
  logic [color_width-1:0] pix_b_i;

  modport master (
    output pix_valid_i, pix_sync_i, pix_r_i, pix_g_i, pix_b_i,
    input  pix_ready_o
  );

  modport slave (
    input  pix_valid_i, pix_sync_i, pix_r_i, pix_g_i, pix_b_i,
    output pix_ready_o
  );
endinterface

// File: rtl/n64a_vdc_hold.sv
// rtl/n64a_vdc_hold.sv - single-entry pixel hold register with valid/ready load side
module n64a_vdc_hold
  import n64a_vdc_tx_pkg::*;
(
  input  logic VCLK,
  input  logic nRST,
  input  logic in_valid,
  input  pix_t in_pix,
  input  logic take,
  output logic full,
  output pix_t q
);

  logic load;

  // Loading is only possible while empty, so a take and a load never collide on a live word.
  assign load = in_valid & ~full;

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      full <= 1'b0;
      q    <= '0;
    end else begin
      if (load) begin
        q <= in_pix;
      end
      full <= load | (full & ~take);
    end
  end

endmodule

// File: rtl/n64a_vdc_tx.sv
// rtl/n64a_vdc_tx.sv - N64 multiplexed video bus transmitter: nDSYNC + D[6:0], sync/R/G/B per 4 VCLK
module n64a_vdc_tx
  import n64a_vdc_tx_pkg::*;
(
  input  logic                   VCLK,
  input  logic                   nRST,
  input  logic                   en_i,
  n64a_vdc_tx_if.slave           pix,
  output logic                   nDSYNC_o,
  output logic [color_width-1:0] D_o,
  output logic                   underrun_o
);

  phase_t                phase_q, phase_d;
  pix_t                  cur_q;
  pix_t                  in_pix;
  pix_t                  hold_q;
  logic                  hold_full;
  logic                  take;
  logic [sync_width-1:0] last_sync_q;
  logic [sync_width-1:0] ps_sync;

  assign in_pix          = {pix.pix_sync_i, pix.pix_r_i, pix.pix_g_i, pix.pix_b_i};
  assign pix.pix_ready_o = ~hold_full;
  assign take            = (phase_d == PH_PS) & hold_full;
  assign ps_sync         = hold_full ? hold_q.sync : last_sync_q;

  n64a_vdc_hold u_hold (
    .VCLK     (VCLK),
    .nRST     (nRST),
    .in_valid (pix.pix_valid_i),
    .in_pix   (in_pix),
    .take     (take),
    .full     (hold_full),
    .q        (hold_q)
  );

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      phase_q <= PH_IDLE;
    end else begin
      phase_q <= phase_d;
    end
  end

  // en_i is only consulted at pixel boundaries so a started pixel always completes.
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      PH_IDLE: phase_d = en_i ? PH_PS : PH_IDLE;
      PH_PS:   phase_d = PH_PR;
      PH_PR:   phase_d = PH_PG;
      PH_PG:   phase_d = PH_PB;
      PH_PB:   phase_d = en_i ? PH_PS : PH_IDLE;
      default: phase_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      cur_q       <= '0;
      last_sync_q <= '1;
      nDSYNC_o    <= 1'b1;
      D_o         <= '0;
      underrun_o  <= 1'b0;
    end else begin
      underrun_o <= 1'b0;
      case (phase_d)
        PH_PS: begin
          // A starved pixel repeats the last sync nibble with black colour.
          if (hold_full) begin
            cur_q       <= hold_q;
            last_sync_q <= hold_q.sync;
          end else begin
            cur_q      <= {last_sync_q, {(3*color_width){1'b0}}};
            underrun_o <= 1'b1;
          end
          nDSYNC_o <= 1'b0;
          D_o      <= sync_to_d(ps_sync);
        end
        PH_PR: begin
          nDSYNC_o <= 1'b1;
          D_o      <= cur_q.r;
        end
        PH_PG: begin
          nDSYNC_o <= 1'b1;
          D_o      <= cur_q.g;
        end
        PH_PB: begin
          nDSYNC_o <= 1'b1;
          D_o      <= cur_q.b;
        end
        default: begin
          nDSYNC_o <= 1'b1;
          D_o      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_n64a_vdc_tx.sv
// tb/tb_n64a_vdc_tx.sv - self-checking bench for n64a_vdc_tx with reference model and bus decoder
module tb_n64a_vdc_tx;
  import n64a_vdc_tx_pkg::*;

  logic       VCLK = 1'b0;
  logic       nRST;
  logic       en_i;
  logic       nDSYNC_o;
  logic [6:0] D_o;
  logic       underrun_o;

  n64a_vdc_tx_if pif ();

  n64a_vdc_tx dut (
    .VCLK       (VCLK),
    .nRST       (nRST),
    .en_i       (en_i),
    .pix        (pif.slave),
    .nDSYNC_o   (nDSYNC_o),
    .D_o        (D_o),
    .underrun_o (underrun_o)
  );

  always #5 VCLK = ~VCLK;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pixel slots of 4 cycles, words flow through a one-deep queue.
  bit         m_idle;
  int         m_pos;
  pix_t       m_hold[$];
  pix_t       m_cur;
  logic [3:0] m_last;
  bit         m_und;
  bit         m_acc;
  pix_t       sb[$];

  task automatic model_reset();
    m_idle = 1; m_pos = 0; m_hold.delete(); m_cur = '0;
    m_last = 4'hF; m_und = 0; m_acc = 0; sb.delete();
  endtask

  task automatic model_step(input bit en, input bit v, input pix_t p);
    m_acc = v && (m_hold.size() == 0);
    m_und = 0;
    if (!m_idle && m_pos < 3) begin
      m_pos++;
    end else if (en) begin
      m_idle = 0;
      m_pos  = 0;
      if (m_hold.size() > 0) begin
        m_cur  = m_hold.pop_front();
        m_last = m_cur.sync;
      end else begin
        m_cur = {m_last, 21'd0};
        m_und = 1;
      end
    end else begin
      m_idle = 1;
    end
    if (m_acc) begin
      m_hold.push_back(p);
      sb.push_back(p);
    end
  endtask

  function automatic logic [6:0] exp_d();
    if (m_idle) return 7'd0;
    case (m_pos)
      0:       return {3'b000, m_cur.sync};
      1:       return m_cur.r;
      2:       return m_cur.g;
      default: return m_cur.b;
    endcase
  endfunction

  task automatic model_compare();
    chk("nDSYNC", nDSYNC_o, (m_idle || m_pos != 0) ? 1 : 0);
    chk("D", D_o, exp_d());
    chk("underrun", underrun_o, m_und);
    chk("ready", pif.pix_ready_o, (m_hold.size() == 0) ? 1 : 0);
  endtask

  task automatic cycle(input bit en, input bit v, input pix_t p);
    en_i            = en;
    pif.pix_valid_i = v;
    {pif.pix_sync_i, pif.pix_r_i, pif.pix_g_i, pif.pix_b_i} = p;
    model_step(en, v, p);
    @(posedge VCLK);
    @(negedge VCLK);
    model_compare();
  endtask

  task automatic drain();
    repeat (8) cycle(1, 0, '0);
    for (int i = 0; i < 8 && !m_idle; i++) cycle(0, 0, '0);
    chk("drain_idle", m_idle, 1);
  endtask

  function automatic pix_t rnd_pix();
    logic [24:0] t;
    t = 25'($urandom());
    return t;
  endfunction

  // Loopback demux: rebuild words from the bus and match against accepted order.
  int         dslot = 0;
  bit         dund;
  logic [3:0] dsync;
  logic [6:0] dr, dg;
  always @(negedge VCLK) begin
    if (!nRST) begin
      dslot = 0;
    end else if (nDSYNC_o == 1'b0) begin
      dsync = D_o[3:0];
      dund  = underrun_o;
      dslot = 1;
    end else if (dslot == 1) begin
      dr = D_o; dslot = 2;
    end else if (dslot == 2) begin
      dg = D_o; dslot = 3;
    end else if (dslot == 3) begin
      dslot = 0;
      if (!dund) begin
        if (sb.size() == 0) chk("loopback_empty", 1, 0);
        else chk("loopback", {dsync, dr, dg, D_o}, sb.pop_front());
      end
    end
  end

  typedef struct {
    bit         en;
    bit         valid;
    pix_t       pix;
    bit         nd;
    logic [6:0] d;
    bit         und;
    bit         rdy;
  } vec_t;

  vec_t vecs[6];
  pix_t p1, p2, pend;
  int   n_acc, guard, last_ps, idx, und_cnt;

  initial begin
    vecs[0] = '{1'b0, 1'b1, {4'hF, 7'h7F, 7'h40, 7'h01}, 1'b1, 7'h00, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, '0, 1'b0, 7'h0F, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 1'b0, '0, 1'b1, 7'h7F, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, '0, 1'b1, 7'h40, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, '0, 1'b1, 7'h01, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 1'b0, '0, 1'b1, 7'h00, 1'b0, 1'b1};

    nRST = 1'b0; en_i = 1'b0; pif.pix_valid_i = 1'b0;
    {pif.pix_sync_i, pif.pix_r_i, pif.pix_g_i, pif.pix_b_i} = '0;
    model_reset();
    repeat (2) @(negedge VCLK);
    chk("rst_nDSYNC", nDSYNC_o, 1);
    chk("rst_D", D_o, 0);
    chk("rst_underrun", underrun_o, 0);
    chk("rst_ready", pif.pix_ready_o, 1);
    nRST = 1'b1;
    repeat (3) cycle(0, 0, '0);

    // Single pixel, table driven
    for (int i = 0; i < 6; i++) begin
      cycle(vecs[i].en, vecs[i].valid, vecs[i].pix);
      chk($sformatf("vec%0d_nDSYNC", i), nDSYNC_o, vecs[i].nd);
      chk($sformatf("vec%0d_D", i), D_o, vecs[i].d);
      chk($sformatf("vec%0d_und", i), underrun_o, vecs[i].und);
      chk($sformatf("vec%0d_ready", i), pif.pix_ready_o, vecs[i].rdy);
    end

    // Reset asserted mid-PG with the hold register full
    p1 = {4'h5, 7'h12, 7'h34, 7'h56};
    p2 = {4'h6, 7'h21, 7'h43, 7'h65};
    cycle(0, 1, p1);
    cycle(1, 0, '0);
    cycle(1, 1, p2);
    cycle(1, 0, '0);
    chk("pg_D_before_rst", D_o, 7'h34);
    nRST = 1'b0;
    #1;
    chk("midrst_nDSYNC", nDSYNC_o, 1);
    chk("midrst_D", D_o, 0);
    chk("midrst_underrun", underrun_o, 0);
    chk("midrst_ready", pif.pix_ready_o, 1);
    model_reset();
    @(negedge VCLK);
    nRST = 1'b1;
    repeat (4) cycle(0, 0, '0);

    // Back-to-back stream of 64 pixels
    pend = rnd_pix();
    cycle(0, 1, pend);
    n_acc = 1; pend = rnd_pix();
    guard = 0; last_ps = -1; idx = 0; und_cnt = 0;
    while (n_acc < 64 && guard < 1000) begin
      cycle(1, 1, pend);
      if (m_acc) begin n_acc++; pend = rnd_pix(); end
      if (underrun_o) und_cnt++;
      if (!nDSYNC_o) begin
        if (last_ps >= 0) chk("stream_spacing", idx - last_ps, 4);
        last_ps = idx;
      end
      idx++; guard++;
    end
    chk("stream_accepted", n_acc, 64);
    chk("stream_underruns", und_cnt, 0);
    drain();

    // Starvation after a pixel with sync 4'hA
    cycle(0, 1, {4'hA, 7'h11, 7'h22, 7'h33});
    und_cnt = 0;
    for (int i = 1; i <= 13; i++) begin
      cycle(1, 0, '0);
      if (underrun_o) und_cnt++;
      if (i == 5) begin
        chk("starve_sync_D", D_o, 7'h0A);
        chk("starve_sync_und", underrun_o, 1);
      end
    end
    chk("starve_und_count", und_cnt, 3);
    drain();

    // en_i dropped during PR keeps the held word for later
    p1 = {4'h3, 7'h01, 7'h02, 7'h03};
    p2 = {4'hC, 7'h44, 7'h55, 7'h66};
    cycle(0, 1, p1);
    cycle(1, 1, p2);
    cycle(0, 1, p2);
    chk("endrop_PR_D", D_o, 7'h01);
    cycle(0, 0, '0);
    cycle(0, 0, '0);
    cycle(0, 0, '0);
    chk("endrop_idle_nDSYNC", nDSYNC_o, 1);
    chk("endrop_idle_D", D_o, 0);
    chk("endrop_hold_kept", pif.pix_ready_o, 0);
    cycle(0, 0, '0);
    cycle(1, 0, '0);
    chk("endrop_resume_D", D_o, 7'h0C);
    chk("endrop_resume_und", underrun_o, 0);
    repeat (3) cycle(0, 0, '0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6, rnd_pix());
    end
    drain();
    repeat (2) cycle(0, 0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
